data_array_ctrl: RTL and testbench

DATA_ARRAY_CTRL -- requirements
Module: data_array_ctrl

---
 rtl/data_array_ctrl_if.sv | 49 ++++
 rtl/data_array_ctrl.sv | 158 +++++++++++++++
 tb/tb_data_array_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_array_ctrl_if.sv
// Bus bundle for data_array_ctrl: core access port, line-fill port and the
// 128-bit single-port SRAM macro port. The controller is the slave side; the
// master side is whatever drives core/fill traffic and models the SRAM.
interface data_array_ctrl_if;
  // core access port
  logic         core_req;
  logic         core_we;
  logic [5:0]   core_idx;
  logic [1:0]   core_off;
  logic [3:0]   core_wstrb;
  logic [31:0]  core_wdata;
  logic         core_gnt;
  logic         core_rvalid;
  logic [31:0]  core_rdata;

  // line-fill port
  logic         fill_valid;
  logic [5:0]   fill_idx;
  logic [31:0]  fill_data;
  logic         fill_last;
  logic         fill_ready;
  logic         fill_done;

  // SRAM macro port
  logic         sram_cs;
  logic         sram_oe;
  logic [15:0]  sram_web;
  logic [5:0]   sram_a;
  logic [127:0] sram_di;
  logic [127:0] sram_do;

  modport slave (
    input  core_req, core_we, core_idx, core_off, core_wstrb, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  fill_valid, fill_idx, fill_data, fill_last,
    output fill_ready, fill_done,
    output sram_cs, sram_oe, sram_web, sram_a, sram_di,
    input  sram_do
  );

  modport master (
    output core_req, core_we, core_idx, core_off, core_wstrb, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output fill_valid, fill_idx, fill_data, fill_last,
    input  fill_ready, fill_done,
    input  sram_cs, sram_oe, sram_web, sram_a, sram_di,
    output sram_do
  );
endinterface

// File: rtl/data_array_ctrl.sv
// data_array_ctrl: arbitrates a 64-line x 4-word data SRAM between single-word
// core accesses and 4-beat line fills. Fill beats are collected in a line
// buffer and written to the SRAM in one full-line cycle (FWRITE). Core
// accesses to the line being filled are stalled until the fill completes.
//
// Optional feature, macro DACTRL_CRIT_WORD_EN: core reads to the line being
// filled whose word has already arrived are served from the line buffer.
//
// Handshakes:
//   core: core_gnt is combinational in the request cycle; the core holds
//         core_req and its fields stable until it sees core_gnt=1. A granted
//         read returns core_rvalid/core_rdata exactly one cycle later.
//   fill: a beat transfers on any cycle with fill_valid && fill_ready.
//         fill_done pulses one cycle after the line is written to the SRAM.
// dbg_state exposes the fill FSM state for checkers.
module data_array_ctrl (
  input  logic                    clk,
  input  logic                    rst,
  data_array_ctrl_if.slave        bus,
  output logic [1:0]              dbg_state
);

`ifdef DACTRL_CRIT_WORD_EN
  localparam bit CritWordEn = 1'b1;
`else
  localparam bit CritWordEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_FWRITE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     beat_q;      // index of the next fill beat
  logic [127:0]   line_q;      // line buffer being assembled
  logic [5:0]     fidx_q;      // target line of the fill in progress
  logic           done_q;
  logic           rvalid_q;
  logic [1:0]     roff_q;      // word offset of the outstanding read
  logic           rbuf_q;      // outstanding read is served from line buffer
  logic [31:0]    rword_q;     // line-buffer word captured for that read

  logic           beat_acc;
  logic           beat_end;
  logic           idx_hit;
  logic           crit_hit;
  logic           gnt;

  assign bus.fill_ready = !rst && (state_q != S_FWRITE);

  // grant and fill-beat decode
  always_comb begin
    beat_acc = bus.fill_valid && bus.fill_ready;
    beat_end = bus.fill_last || (beat_q == 2'd3);
    idx_hit  = (state_q == S_FILL) && (bus.core_idx == fidx_q);
    crit_hit = CritWordEn && idx_hit && !bus.core_we && (bus.core_off < beat_q);
    gnt      = !rst && bus.core_req && (state_q != S_FWRITE) && (!idx_hit || crit_hit);
  end

  // next-state logic; a first beat already flagged last goes straight to the line write
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (beat_acc) state_d = bus.fill_last ? S_FWRITE : S_FILL;
      S_FILL:   if (beat_acc && beat_end) state_d = S_FWRITE;
      S_FWRITE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // line buffer assembly; the first beat clears the buffer so missing words write as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= 2'd0;
      line_q <= '0;
      fidx_q <= 6'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_FWRITE);
      if (state_q == S_FWRITE) begin
        beat_q <= 2'd0;
      end else if (beat_acc) begin
        if (state_q == S_IDLE) begin
          fidx_q <= bus.fill_idx;
          line_q <= {96'd0, bus.fill_data};
          beat_q <= 2'd1;
        end else begin
          line_q[{beat_q, 5'd0} +: 32] <= bus.fill_data;
          beat_q <= beat_q + 2'd1;
        end
      end
    end
  end

  // read-return tracking for the cycle after a read grant
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      roff_q   <= 2'd0;
      rbuf_q   <= 1'b0;
      rword_q  <= 32'd0;
    end else begin
      rvalid_q <= gnt && !bus.core_we;
      if (gnt && !bus.core_we) begin
        roff_q  <= bus.core_off;
        rbuf_q  <= crit_hit;
        rword_q <= line_q[{bus.core_off, 5'd0} +: 32];
      end
    end
  end

  // SRAM port: line write has priority, otherwise a granted core access
  always_comb begin
    bus.sram_cs  = 1'b0;
    bus.sram_oe  = 1'b0;
    bus.sram_web = 16'hFFFF;
    bus.sram_a   = 6'd0;
    bus.sram_di  = '0;
    if (!rst && (state_q == S_FWRITE)) begin
      bus.sram_cs  = 1'b1;
      bus.sram_web = 16'h0000;
      bus.sram_a   = fidx_q;
      bus.sram_di  = line_q;
    end else if (gnt && !crit_hit) begin
      bus.sram_cs = 1'b1;
      bus.sram_a  = bus.core_idx;
      if (bus.core_we) begin
        bus.sram_di = {4{bus.core_wdata}};
        for (int w = 0; w < 4; w++) begin
          if (bus.core_off == w[1:0]) bus.sram_web[4*w +: 4] = ~bus.core_wstrb;
        end
      end else begin
        bus.sram_oe = 1'b1;
      end
    end
  end

  // core-facing outputs; registered flags are masked while reset is asserted
  always_comb begin
    bus.core_gnt    = gnt;
    bus.core_rvalid = rvalid_q && !rst;
    bus.core_rdata  = 32'd0;
    if (bus.core_rvalid) begin
      bus.core_rdata = rbuf_q ? rword_q : bus.sram_do[{roff_q, 5'd0} +: 32];
    end
    bus.fill_done = done_q && !rst;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_data_array_ctrl.sv
// Testbench for data_array_ctrl. Inputs change on the falling edge, outputs
// are sampled 1ns later. A 64 x 128-bit SRAM behavioural model answers the
// SRAM port; a word-level reference memory tracks what every line should hold.
module tb_data_array_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;
  int checks = 0;
  int errors = 0;

  logic [127:0] sram_mem [64];
  logic [31:0]  ref_mem [256];
  logic [31:0]  exp_q [$];

  always #5 clk = ~clk;

  data_array_ctrl_if ifc ();

  data_array_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .dbg_state (dbg_state)
  );

  // SRAM model: byte-masked write, registered read
  always @(posedge clk) begin
    if (ifc.sram_cs) begin
      if (ifc.sram_oe) ifc.sram_do <= sram_mem[ifc.sram_a];
      else begin
        for (int b = 0; b < 16; b++)
          if (!ifc.sram_web[b]) sram_mem[ifc.sram_a][8*b +: 8] <= ifc.sram_di[8*b +: 8];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // reference model updates
  task automatic ref_write(input logic [5:0] idx, input logic [1:0] off,
                           input logic [3:0] strb, input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (strb[b]) ref_mem[idx*4 + off][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic ref_fill(input logic [5:0] idx, input logic [127:0] d, input int nb);
    for (int w = 0; w < 4; w++) ref_mem[idx*4 + w] = (w < nb) ? d[32*w +: 32] : 32'd0;
  endtask

  // driver: one core access, held until granted (bounded), returns SRAM view and read data
  task automatic core_op(input logic we, input logic [5:0] idx, input logic [1:0] off,
                         input logic [3:0] strb, input logic [31:0] wd,
                         output bit granted, output int waits, output logic [15:0] web,
                         output logic [5:0] a, output logic [127:0] di, output logic cs,
                         output logic oe, output logic rv, output logic [31:0] rd);
    granted = 0; waits = 0; web = 'x; a = 'x; di = 'x; cs = 'x; oe = 'x;
    @(negedge clk);
    ifc.core_req = 1'b1; ifc.core_we = we; ifc.core_idx = idx;
    ifc.core_off = off; ifc.core_wstrb = strb; ifc.core_wdata = wd;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (ifc.core_gnt === 1'b1) begin
        granted = 1; web = ifc.sram_web; a = ifc.sram_a; di = ifc.sram_di;
        cs = ifc.sram_cs; oe = ifc.sram_oe;
        break;
      end
      waits++;
      @(negedge clk);
    end
    @(negedge clk);
    ifc.core_req = 1'b0;
    #1;
    rv = ifc.core_rvalid; rd = ifc.core_rdata;
  endtask

  // driver: nb consecutive fill beats, last flagged on the final one; returns in the cycle after
  task automatic fill_send(input logic [5:0] idx, input logic [127:0] d, input int nb);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      ifc.fill_valid = 1'b1; ifc.fill_idx = idx;
      ifc.fill_data = d[32*i +: 32]; ifc.fill_last = (i == nb - 1);
    end
    @(negedge clk);
    ifc.fill_valid = 1'b0; ifc.fill_last = 1'b0;
  endtask

  task automatic test_reset();
    ifc.core_req = 1'b1; ifc.core_we = 1'b0; ifc.core_idx = 6'd7; ifc.core_off = 2'd1;
    ifc.fill_valid = 1'b1; ifc.fill_idx = 6'd2; ifc.fill_data = 32'h1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ifc.core_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b expected 0", ifc.core_gnt); end
    checks++; if (ifc.fill_ready !== 1'b0) begin errors++; $display("FAIL rst_fill_ready: got %b expected 0", ifc.fill_ready); end
    checks++; if ({ifc.sram_cs, ifc.sram_oe, ifc.sram_web, ifc.sram_a} !== {2'b00, 16'hFFFF, 6'd0} || ifc.sram_di !== 128'd0) begin
      errors++; $display("FAIL rst_sram: got cs=%b oe=%b web=%h a=%h di=%h expected idle", ifc.sram_cs, ifc.sram_oe, ifc.sram_web, ifc.sram_a, ifc.sram_di); end
    checks++; if ({ifc.core_rvalid, ifc.core_rdata, ifc.fill_done} !== 34'd0) begin
      errors++; $display("FAIL rst_outs: got rvalid=%b rdata=%h done=%b expected 0", ifc.core_rvalid, ifc.core_rdata, ifc.fill_done); end
    @(negedge clk);
    rst = 1'b0; ifc.core_req = 1'b0; ifc.fill_valid = 1'b0;
    #1;
    checks++; if (ifc.fill_ready !== 1'b1) begin errors++; $display("FAIL idle_fill_ready: got %b expected 1", ifc.fill_ready); end
    // reset in the cycle right after a read grant hides the return
    @(negedge clk);
    ifc.core_req = 1'b1; ifc.core_we = 1'b0; ifc.core_idx = 6'd5; ifc.core_off = 2'd0;
    #1;
    checks++; if (ifc.core_gnt !== 1'b1) begin errors++; $display("FAIL rrst_gnt: got %b expected 1", ifc.core_gnt); end
    @(negedge clk);
    ifc.core_req = 1'b0; rst = 1'b1;
    #1;
    checks++; if (ifc.core_rvalid !== 1'b0) begin errors++; $display("FAIL rrst_rvalid: got %b expected 0", ifc.core_rvalid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ifc.core_rvalid !== 1'b0) begin errors++; $display("FAIL rrst_rvalid_after: got %b expected 0", ifc.core_rvalid); end
  endtask

  task automatic test_core_write_read();
    bit g; int w; logic [15:0] web; logic [5:0] a; logic [127:0] di; logic cs, oe, rv; logic [31:0] rd;
    core_op(1'b1, 6'd5, 2'd2, 4'b0011, 32'hA5A5_1234, g, w, web, a, di, cs, oe, rv, rd);
    checks++; if (!g || w != 0) begin errors++; $display("FAIL wr_gnt: got granted=%0d waits=%0d expected 1/0", g, w); end
    checks++; if (web !== 16'hFCFF) begin errors++; $display("FAIL wr_web: got %h expected fcff", web); end
    checks++; if ({cs, oe, a} !== {2'b10, 6'd5} || di !== {4{32'hA5A5_1234}}) begin
      errors++; $display("FAIL wr_sram: got cs=%b oe=%b a=%h di=%h expected 1 0 05 replicated", cs, oe, a, di); end
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL wr_norvalid: got %b expected 0", rv); end
    ref_write(6'd5, 2'd2, 4'b0011, 32'hA5A5_1234);
    core_op(1'b0, 6'd5, 2'd2, 4'b0000, 32'd0, g, w, web, a, di, cs, oe, rv, rd);
    checks++; if (!g || w != 0 || web !== 16'hFFFF || oe !== 1'b1 || a !== 6'd5) begin
      errors++; $display("FAIL rd_req: got granted=%0d waits=%0d web=%h oe=%b a=%h expected 1 0 ffff 1 05", g, w, web, oe, a); end
    checks++; if (rv !== 1'b1 || rd[15:0] !== 16'h1234 || rd !== ref_mem[22]) begin
      errors++; $display("FAIL rd_data: got rvalid=%b rdata=%h expected 1 %h", rv, rd, ref_mem[22]); end
  endtask

  task automatic test_fill_full();
    logic [127:0] d = {32'd44, 32'd33, 32'd22, 32'd11};
    fill_send(6'd9, d, 4);
    ifc.core_req = 1'b1; ifc.core_we = 1'b0; ifc.core_idx = 6'd20; ifc.core_off = 2'd3;
    #1;
    checks++; if ({ifc.sram_cs, ifc.sram_oe, ifc.sram_web, ifc.sram_a} !== {2'b10, 16'h0000, 6'd9} || ifc.sram_di !== d) begin
      errors++; $display("FAIL ff_write: got cs=%b oe=%b web=%h a=%h di=%h expected 1 0 0000 09 %h", ifc.sram_cs, ifc.sram_oe, ifc.sram_web, ifc.sram_a, ifc.sram_di, d); end
    checks++; if (ifc.fill_ready !== 1'b0 || ifc.core_gnt !== 1'b0 || ifc.fill_done !== 1'b0) begin
      errors++; $display("FAIL ff_fwrite_ctl: got ready=%b gnt=%b done=%b expected 0 0 0", ifc.fill_ready, ifc.core_gnt, ifc.fill_done); end
    ref_fill(6'd9, d, 4);
    @(negedge clk); #1;
    checks++; if (ifc.fill_done !== 1'b1 || ifc.core_gnt !== 1'b1 || ifc.sram_a !== 6'd20) begin
      errors++; $display("FAIL ff_done: got done=%b gnt=%b a=%h expected 1 1 14", ifc.fill_done, ifc.core_gnt, ifc.sram_a); end
    @(negedge clk);
    ifc.core_req = 1'b0;
    #1;
    checks++; if (ifc.fill_done !== 1'b0 || ifc.core_rvalid !== 1'b1 || ifc.core_rdata !== ref_mem[83]) begin
      errors++; $display("FAIL ff_after: got done=%b rvalid=%b rdata=%h expected 0 1 %h", ifc.fill_done, ifc.core_rvalid, ifc.core_rdata, ref_mem[83]); end
  endtask

  task automatic test_fill_short();
    logic [127:0] d = {32'hDEAD, 32'hBEEF, 32'd8, 32'd7};
    fill_send(6'd3, d, 2);
    #1;
    checks++; if (ifc.sram_cs !== 1'b1 || ifc.sram_a !== 6'd3 || ifc.sram_di !== {32'd0, 32'd0, 32'd8, 32'd7}) begin
      errors++; $display("FAIL fs_line: got cs=%b a=%h di=%h expected 1 03 zero-padded", ifc.sram_cs, ifc.sram_a, ifc.sram_di); end
    ref_fill(6'd3, d, 2);
    @(negedge clk); #1;
    checks++; if (ifc.fill_done !== 1'b1) begin errors++; $display("FAIL fs_done: got %b expected 1", ifc.fill_done); end
  endtask

  task automatic test_hazard();
    logic [127:0] d = {32'd400, 32'd300, 32'd200, 32'd100};
    @(negedge clk);
    ifc.fill_valid = 1'b1; ifc.fill_idx = 6'd9; ifc.fill_data = 32'd100; ifc.fill_last = 1'b0;
    @(negedge clk);
    ifc.fill_data = 32'd200;
    @(negedge clk);
    ifc.fill_valid = 1'b0;
    ifc.core_req = 1'b1; ifc.core_we = 1'b0; ifc.core_idx = 6'd4; ifc.core_off = 2'd0;
    #1;
    checks++; if (ifc.core_gnt !== 1'b1 || ifc.sram_cs !== 1'b1 || ifc.sram_a !== 6'd4 || ifc.sram_oe !== 1'b1) begin
      errors++; $display("FAIL hz_other_idx: got gnt=%b cs=%b a=%h oe=%b expected 1 1 04 1", ifc.core_gnt, ifc.sram_cs, ifc.sram_a, ifc.sram_oe); end
    @(negedge clk);
    #1;
    checks++; if (ifc.core_rvalid !== 1'b1 || ifc.core_rdata !== ref_mem[16]) begin
      errors++; $display("FAIL hz_other_data: got rvalid=%b rdata=%h expected 1 %h", ifc.core_rvalid, ifc.core_rdata, ref_mem[16]); end
    ifc.core_idx = 6'd9; ifc.core_off = 2'd1;
    #1;
`ifdef DACTRL_CRIT_WORD_EN
    checks++; if (ifc.core_gnt !== 1'b1 || ifc.sram_cs !== 1'b0) begin
      errors++; $display("FAIL hz_crit_gnt: got gnt=%b cs=%b expected 1 0", ifc.core_gnt, ifc.sram_cs); end
    @(negedge clk);
    ifc.core_req = 1'b0; ifc.fill_valid = 1'b1; ifc.fill_data = 32'd300;
    #1;
    checks++; if (ifc.core_rvalid !== 1'b1 || ifc.core_rdata !== 32'd200 || ifc.sram_cs !== 1'b0) begin
      errors++; $display("FAIL hz_crit_data: got rvalid=%b rdata=%h cs=%b expected 1 000000c8 0", ifc.core_rvalid, ifc.core_rdata, ifc.sram_cs); end
`else
    checks++; if (ifc.core_gnt !== 1'b0 || ifc.sram_cs !== 1'b0) begin
      errors++; $display("FAIL hz_stall: got gnt=%b cs=%b expected 0 0", ifc.core_gnt, ifc.sram_cs); end
    @(negedge clk);
    ifc.fill_valid = 1'b1; ifc.fill_data = 32'd300;
    #1;
    checks++; if (ifc.core_gnt !== 1'b0 || ifc.core_rvalid !== 1'b0) begin
      errors++; $display("FAIL hz_stall2: got gnt=%b rvalid=%b expected 0 0", ifc.core_gnt, ifc.core_rvalid); end
`endif
    @(negedge clk);
    ifc.fill_data = 32'd400; ifc.fill_last = 1'b1;
`ifndef DACTRL_CRIT_WORD_EN
    #1;
    checks++; if (ifc.core_gnt !== 1'b0) begin errors++; $display("FAIL hz_stall3: got %b expected 0", ifc.core_gnt); end
`endif
    @(negedge clk);
    ifc.fill_valid = 1'b0; ifc.fill_last = 1'b0;
    #1;
    checks++; if (ifc.sram_cs !== 1'b1 || ifc.sram_web !== 16'h0000 || ifc.sram_a !== 6'd9 || ifc.sram_di !== d || ifc.core_gnt !== 1'b0) begin
      errors++; $display("FAIL hz_write: got cs=%b web=%h a=%h di=%h gnt=%b expected 1 0000 09 %h 0", ifc.sram_cs, ifc.sram_web, ifc.sram_a, ifc.sram_di, ifc.core_gnt, d); end
    ref_fill(6'd9, d, 4);
    @(negedge clk);
    #1;
    checks++; if (ifc.fill_done !== 1'b1) begin errors++; $display("FAIL hz_done: got %b expected 1", ifc.fill_done); end
`ifndef DACTRL_CRIT_WORD_EN
    checks++; if (ifc.core_gnt !== 1'b1 || ifc.sram_a !== 6'd9 || ifc.sram_oe !== 1'b1) begin
      errors++; $display("FAIL hz_release: got gnt=%b a=%h oe=%b expected 1 09 1", ifc.core_gnt, ifc.sram_a, ifc.sram_oe); end
    @(negedge clk);
    ifc.core_req = 1'b0;
    #1;
    checks++; if (ifc.core_rvalid !== 1'b1 || ifc.core_rdata !== ref_mem[37]) begin
      errors++; $display("FAIL hz_rdata: got rvalid=%b rdata=%h expected 1 %h", ifc.core_rvalid, ifc.core_rdata, ref_mem[37]); end
`endif
  endtask

  task automatic test_reset_mid_fill();
    logic [127:0] d = {32'd0, 32'd0, 32'hC0DE_0002, 32'hC0DE_0001};
    bit g; int w; logic [15:0] web; logic [5:0] a; logic [127:0] di; logic cs, oe, rv; logic [31:0] rd;
    @(negedge clk);
    ifc.fill_valid = 1'b1; ifc.fill_idx = 6'd12; ifc.fill_data = 32'h1111_0000; ifc.fill_last = 1'b0;
    @(negedge clk);
    ifc.fill_data = 32'h2222_0000;
    @(negedge clk);
    ifc.fill_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (ifc.fill_ready !== 1'b0 || ifc.sram_cs !== 1'b0) begin
      errors++; $display("FAIL rmf_rst: got ready=%b cs=%b expected 0 0", ifc.fill_ready, ifc.sram_cs); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ifc.sram_cs !== 1'b0 || ifc.fill_done !== 1'b0) begin
        errors++; $display("FAIL rmf_quiet: got cs=%b done=%b expected 0 0", ifc.sram_cs, ifc.fill_done); end
      @(negedge clk);
    end
    fill_send(6'd13, d, 2);
    #1;
    checks++; if (ifc.sram_a !== 6'd13 || ifc.sram_di !== d || ifc.sram_cs !== 1'b1) begin
      errors++; $display("FAIL rmf_refill: got cs=%b a=%h di=%h expected 1 0d %h", ifc.sram_cs, ifc.sram_a, ifc.sram_di, d); end
    ref_fill(6'd13, d, 2);
    core_op(1'b0, 6'd12, 2'd1, 4'd0, 32'd0, g, w, web, a, di, cs, oe, rv, rd);
    checks++; if (!g || rv !== 1'b1 || rd !== ref_mem[49]) begin
      errors++; $display("FAIL rmf_untouched: got granted=%0d rvalid=%b rdata=%h expected 1 1 %h", g, rv, rd, ref_mem[49]); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] da = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    bit g; int w; logic [15:0] web; logic [5:0] a; logic [127:0] di; logic cs, oe, rv; logic [31:0] rd;
    fill_send(6'd20, da, 4);
    ifc.fill_valid = 1'b1; ifc.fill_idx = 6'd21; ifc.fill_data = 32'hB0;
    #1;
    checks++; if (ifc.fill_ready !== 1'b0 || ifc.sram_a !== 6'd20 || ifc.sram_di !== da) begin
      errors++; $display("FAIL b2b_fwrite: got ready=%b a=%h di=%h expected 0 14 %h", ifc.fill_ready, ifc.sram_a, ifc.sram_di, da); end
    ref_fill(6'd20, da, 4);
    @(negedge clk); #1;
    checks++; if (ifc.fill_done !== 1'b1 || ifc.fill_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_done: got done=%b ready=%b expected 1 1", ifc.fill_done, ifc.fill_ready); end
    @(negedge clk);
    ifc.fill_data = 32'hB1; ifc.fill_last = 1'b1;
    ifc.core_req = 1'b1; ifc.core_we = 1'b1; ifc.core_idx = 6'd30; ifc.core_off = 2'd0;
    ifc.core_wstrb = 4'hF; ifc.core_wdata = 32'h5EED_F00D;
    #1;
    checks++; if (ifc.core_gnt !== 1'b1 || ifc.sram_a !== 6'd30 || ifc.sram_web !== 16'hFFF0 || ifc.fill_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_concurrent: got gnt=%b a=%h web=%h ready=%b expected 1 1e fff0 1", ifc.core_gnt, ifc.sram_a, ifc.sram_web, ifc.fill_ready); end
    ref_write(6'd30, 2'd0, 4'hF, 32'h5EED_F00D);
    @(negedge clk);
    ifc.fill_valid = 1'b0; ifc.fill_last = 1'b0; ifc.core_req = 1'b0;
    #1;
    checks++; if (ifc.sram_a !== 6'd21 || ifc.sram_web !== 16'h0000 || ifc.sram_di !== {64'd0, 32'hB1, 32'hB0}) begin
      errors++; $display("FAIL b2b_second: got a=%h web=%h di=%h expected 15 0000 {0,0,b1,b0}", ifc.sram_a, ifc.sram_web, ifc.sram_di); end
    ref_fill(6'd21, {64'd0, 32'hB1, 32'hB0}, 2);
    core_op(1'b0, 6'd30, 2'd0, 4'd0, 32'd0, g, w, web, a, di, cs, oe, rv, rd);
    checks++; if (!g || rv !== 1'b1 || rd !== ref_mem[120]) begin
      errors++; $display("FAIL b2b_rd30: got granted=%0d rvalid=%b rdata=%h expected 1 1 %h", g, rv, rd, ref_mem[120]); end
    core_op(1'b0, 6'd20, 2'd3, 4'd0, 32'd0, g, w, web, a, di, cs, oe, rv, rd);
    checks++; if (!g || rv !== 1'b1 || rd !== ref_mem[83]) begin
      errors++; $display("FAIL b2b_rd20: got granted=%0d rvalid=%b rdata=%h expected 1 1 %h", g, rv, rd, ref_mem[83]); end
  endtask

  task automatic test_random();
    bit g; int w; logic [15:0] web; logic [5:0] a; logic [127:0] di; logic cs, oe, rv; logic [31:0] rd;
    logic [5:0] idx; logic [1:0] off; logic [3:0] strb; logic [31:0] wd; logic we;
    logic [127:0] d; int nb; logic [15:0] exp_web; logic [31:0] exp_rd;
    for (int n = 0; n < 60; n++) begin
      idx = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 2) begin
        nb = $urandom_range(2, 4);
        d = {$urandom, $urandom, $urandom, $urandom};
        fill_send(idx, d, nb);
        ref_fill(idx, d, nb);
        #1;
        checks++; if (ifc.sram_a !== idx || ifc.sram_web !== 16'h0000 ||
                      ifc.sram_di !== {ref_mem[idx*4+3], ref_mem[idx*4+2], ref_mem[idx*4+1], ref_mem[idx*4]}) begin
          errors++; $display("FAIL rnd_fill: got a=%h web=%h di=%h expected %h 0000 nb=%0d", ifc.sram_a, ifc.sram_web, ifc.sram_di, idx, nb); end
        @(negedge clk); #1;
        checks++; if (ifc.fill_done !== 1'b1) begin errors++; $display("FAIL rnd_done: got %b expected 1", ifc.fill_done); end
      end else begin
        we = 1'($urandom_range(0, 1));
        off = 2'($urandom_range(0, 3));
        strb = 4'($urandom_range(0, 15));
        wd = $urandom;
        if (!we) exp_q.push_back(ref_mem[idx*4 + off]);
        core_op(we, idx, off, strb, wd, g, w, web, a, di, cs, oe, rv, rd);
        checks++; if (!g || w != 0 || a !== idx || cs !== 1'b1) begin
          errors++; $display("FAIL rnd_gnt: got granted=%0d waits=%0d a=%h cs=%b expected 1 0 %h 1", g, w, a, cs, idx); end
        if (we) begin
          exp_web = 16'hFFFF ^ (16'(strb) << (4 * off));
          checks++; if (web !== exp_web || di !== {4{wd}} || oe !== 1'b0 || rv !== 1'b0) begin
            errors++; $display("FAIL rnd_write: got web=%h oe=%b rvalid=%b expected %h 0 0", web, oe, rv, exp_web); end
          ref_write(idx, off, strb, wd);
        end else begin
          exp_rd = exp_q.pop_front();
          checks++; if (rv !== 1'b1 || rd !== exp_rd || web !== 16'hFFFF) begin
            errors++; $display("FAIL rnd_read: got rvalid=%b rdata=%h web=%h expected 1 %h ffff", rv, rd, web, exp_rd); end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sram_mem[i] = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    ifc.core_req = 1'b0; ifc.core_we = 1'b0; ifc.core_idx = '0; ifc.core_off = '0;
    ifc.core_wstrb = '0; ifc.core_wdata = '0;
    ifc.fill_valid = 1'b0; ifc.fill_idx = '0; ifc.fill_data = '0; ifc.fill_last = 1'b0;
    test_reset();
    test_core_write_read();
    test_fill_full();
    test_fill_short();
    test_hazard();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
